// File: rtl/serial_comparator_pkg.sv
// Shared definitions for the MSB-first serial magnitude comparator:
// FSM state encodings, the decision type and the default word width.
package serial_comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DEC_UNDECIDED = 2'd0,
        DEC_GT        = 2'd1,
        DEC_LT        = 2'd2
    } decision_t;

endpackage

// File: rtl/serial_comparator_ctrl.sv
// Sequencing FSM and accepted-pair counter for the serial comparator.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for start; bit_valid ignored
//   ST_COMPARE | accepting one bit pair per bit_valid cycle; start ignored
//   ST_DONE    | one-cycle result strobe; start here chains a new compare
module serial_comparator_ctrl
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    output logic busy,
    output logic done,
    output logic accept,
    output logic clear,
    output logic last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        clear      = 1'b0;
        last       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_COMPARE;
                    cnt_next   = '0;
                    clear      = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (bit_valid) begin
                    accept   = 1'b1;
                    cnt_next = cnt + CW'(1);
                    if (cnt == LAST_IDX) begin
                        last       = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next = ST_COMPARE;
                    cnt_next   = '0;
                    clear      = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state == ST_COMPARE);
    assign done = (state == ST_DONE);

endmodule

// File: rtl/serial_comparator.sv
// MSB-first serial magnitude comparator: the first differing bit pair decides,
// but the result is only published once all WIDTH pairs have been consumed.
module serial_comparator
    import serial_comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic x,
    input  logic y,
    output logic busy,
    output logic done,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic      accept, clear, last;
    decision_t dec, dec_now;

    serial_comparator_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bit_valid(bit_valid),
        .busy     (busy),
        .done     (done),
        .accept   (accept),
        .clear    (clear),
        .last     (last)
    );

    // Decision including the pair on the bus now, so the final pair counts.
    always_comb begin
        dec_now = dec;
        if (dec == DEC_UNDECIDED && x != y)
            dec_now = x ? DEC_GT : DEC_LT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec <= DEC_UNDECIDED;
            gt  <= 1'b0;
            eq  <= 1'b0;
            lt  <= 1'b0;
        end else begin
            if (clear)
                dec <= DEC_UNDECIDED;
            else if (accept)
                dec <= dec_now;
            if (last) begin
                gt <= (dec_now == DEC_GT);
                eq <= (dec_now == DEC_UNDECIDED);
                lt <= (dec_now == DEC_LT);
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: directed scenarios plus random traffic, all
// checked every cycle against a word-level model that compares integers.
module tb_serial_comparator;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n, start, bit_valid, x, y;
    logic busy, done, gt, eq, lt;

    int tests = 0;
    int fails = 0;

    serial_comparator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
        .x(x), .y(y), .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: collects accepted bits into integers and compares them.
    bit          m_active, m_done, m_gt, m_eq, m_lt;
    int          m_n;
    int unsigned m_xv, m_yv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_n = 0;
            m_gt = 0; m_eq = 0; m_lt = 0;
        end else begin
            bit was_done;
            was_done = m_done;
            m_done   = 0;
            if (was_done || !m_active) begin
                m_active = start;
                m_n = 0; m_xv = 0; m_yv = 0;
            end else if (bit_valid) begin
                m_xv = (m_xv << 1) | int'(x);
                m_yv = (m_yv << 1) | int'(y);
                m_n++;
                if (m_n == WIDTH) begin
                    m_active = 0;
                    m_done   = 1;
                    m_gt = (m_xv > m_yv);
                    m_eq = (m_xv == m_yv);
                    m_lt = (m_xv < m_yv);
                end
            end
        end
        #1;
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
        check("res", {29'd0, gt, eq, lt}, {29'd0, m_gt, m_eq, m_lt});
    end

    // Sends one word MSB first; optional stall before every pair and an
    // optional start pulse alongside pair index start_at (0 = first pair).
    task automatic send_word(input logic [7:0] xw, input logic [7:0] yw,
                             input bit stalls, input int start_at);
        for (int i = 0; i < WIDTH; i++) begin
            if (stalls) begin
                bit_valid = 0;
                @(negedge clk);
            end
            bit_valid = 1;
            x = xw[WIDTH-1-i];
            y = yw[WIDTH-1-i];
            start = (i == start_at);
            @(negedge clk);
        end
        bit_valid = 0;
        start = 0;
    endtask

    task automatic kick();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic check_result(input string name, input logic [2:0] exp_gel);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_gel"}, 32'({gt, eq, lt}), 32'(exp_gel));
    endtask

    initial begin
        rst_n = 0; start = 0; bit_valid = 0; x = 0; y = 0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 32'({busy, done, gt, eq, lt}), 32'd0);
        rst_n = 1;
        @(negedge clk);

        // Equal operands
        kick();
        check("busy_after_start", 32'(busy), 32'd1);
        send_word(8'hA5, 8'hA5, 0, -1);
        check_result("eq_a5", 3'b010);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Early decision must not publish before the last pair
        kick();
        bit_valid = 1; x = 1; y = 0;
        @(negedge clk);
        check("early_not_pub", 32'({gt, eq, lt}), 32'b010);
        check("early_busy", 32'(busy), 32'd1);
        bit_valid = 0;
        for (int i = 1; i < WIDTH; i++) begin
            bit_valid = 1; x = 1'b0; y = 1'b1;
            @(negedge clk);
            if (i < WIDTH - 1) check("early_busy_mid", 32'(busy), 32'd1);
        end
        bit_valid = 0;
        check_result("gt_80_7f", 3'b100);
        @(negedge clk);

        // Stalls on alternate cycles: done 17 cycles after start
        kick();
        send_word(8'h01, 8'h02, 1, -1);
        check_result("lt_stall", 3'b001);

        // Back-to-back: start in the DONE cycle
        start = 1;
        @(negedge clk);
        start = 0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_held", 32'({gt, eq, lt}), 32'b001);
        send_word(8'h00, 8'h00, 0, -1);
        check_result("b2b_eq", 3'b010);
        @(negedge clk);

        // Reset mid-compare
        kick();
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1; x = 1; y = 0;
            @(negedge clk);
        end
        bit_valid = 0;
        rst_n = 0;
        #1;
        check("mid_reset_outs", 32'({busy, done, gt, eq, lt}), 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", 32'({busy, done}), 32'd0);
        kick();
        send_word(8'hFF, 8'h00, 0, -1);
        check_result("gt_ff_00", 3'b100);
        @(negedge clk);

        // Ignored inputs: bit_valid with start in IDLE, start mid-compare
        start = 1; bit_valid = 1; x = 1; y = 0;
        @(negedge clk);
        start = 0; bit_valid = 0;
        send_word(8'h0F, 8'h3C, 0, 3);
        check_result("ignored_lt", 3'b001);
        @(negedge clk);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 7) == 0);
            bit_valid = ($urandom_range(0, 3) != 0);
            x         = 1'($urandom_range(0, 1));
            y         = ($urandom_range(0, 2) == 0) ? 1'($urandom_range(0, 1)) : x;
            if ($urandom_range(0, 299) == 0) rst_n = 0;
            else rst_n = 1;
            @(negedge clk);
        end
        rst_n = 1; start = 0; bit_valid = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, number of bit pairs per compared word (legal range 1..32).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset: asynchronous and active-low.
REQ-004 start  input  1  request to begin a new comparison.
REQ-005 bit_valid  input  1  x/y carry a valid bit pair this cycle.
REQ-006 x  input  1  current bit of operand X, MSB first.
REQ-007 y  input  1  current bit of operand Y, MSB first.
REQ-008 busy  output  1  high while in COMPARE; also means the block accepts bits.
REQ-009 done  output  1  one-cycle pulse; the result is valid.
REQ-010 gt  output  1  X > Y for the last completed comparison.
REQ-011 eq  output  1  X == Y for the last completed comparison.
REQ-012 lt  output  1  X < Y for the last completed comparison.

Function
REQ-013 The FSM shall have three states: IDLE, COMPARE, DONE.
REQ-014 IDLE: start=1 -> COMPARE on the next edge; bit counter cleared to 0; internal decision cleared to "undecided".
REQ-015 IDLE: bit_valid shall be ignored, including when bit_valid and start are high in the same cycle; the first bit is accepted one cycle after start at the earliest.
REQ-016 COMPARE: a bit pair is accepted on each edge where bit_valid=1; the counter increments by 1 per accepted pair.
REQ-017 COMPARE: bit_valid=0 cycles are stalls; counter and decision hold.
REQ-018 Decision rule: the first accepted pair with x!=y fixes the decision (x=1,y=0 -> GT; x=0,y=1 -> LT); later pairs do not change it.
REQ-019 The block shall consume all WIDTH pairs even after an early decision; the result is not published early.
REQ-020 On the edge accepting pair WIDTH, the state shall go to DONE; gt/eq/lt update on that same edge (undecided -> eq=1).
REQ-021 DONE lasts exactly one cycle; done=1 only in DONE (one-cycle latency after the last accepted pair).
REQ-022 DONE: start=1 -> COMPARE directly (back-to-back); otherwise -> IDLE.
REQ-023 start during COMPARE shall be ignored; the comparison in progress continues.
REQ-024 gt/eq/lt shall hold their value from the last DONE until the next transition into DONE; exactly one is high after the first completed comparison.
REQ-025 Counter width shall be clog2(WIDTH+1) bits; it never wraps within a comparison.
REQ-026 WIDTH=1: a single accepted pair moves the FSM COMPARE -> DONE.

Reset
REQ-027 rst_n low shall asynchronously force IDLE, counter=0, decision undecided, busy=0, done=0, gt=0, eq=0, lt=0.
REQ-028 Reset asserted mid-COMPARE shall abandon the comparison with no done pulse; after release the block waits for a new start.
REQ-029 Reset release shall be sampled synchronously; the first start is honoured on the first edge after rst_n is seen high.

Structure
REQ-030 The state encodings (IDLE=2'd0, COMPARE=2'd1, DONE=2'd2) and the default WIDTH shall live in a shared serial_comparator_pkg include.
REQ-031 The FSM and counter shall be one sub-module, serial_comparator_ctrl; decision and result registers stay in the top level.

Verification (WIDTH=8)
REQ-032 Equal operands: start, then X=8'hA5, Y=8'hA5 with bit_valid on 8 consecutive cycles -> done one cycle after the 8th pair; eq=1, gt=0, lt=0.
REQ-033 Early decision: X=8'h80, Y=8'h7F -> gt=1 only after all 8 pairs, not after pair 1; busy high for all 8 accept cycles.
REQ-034 Stalls: X=8'h01, Y=8'h02 with bit_valid low on alternate cycles -> lt=1; done 1 cycle after the 8th accepted pair (16 cycles after start + 1).
REQ-035 Back-to-back: start held high in the DONE cycle -> COMPARE next edge; second pair X=8'h00, Y=8'h00 -> eq=1; first result held until the second done.
REQ-036 Reset mid-operation: rst_n low after 4 pairs -> all outputs 0 immediately, no done; a new start with X=8'hFF, Y=8'h00 -> gt=1.
REQ-037 Ignored inputs: bit_valid=1 with start in IDLE, and start pulsed mid-COMPARE -> neither shifts the bit count; the result matches the 8 pairs accepted in COMPARE.
